// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem request/ready handshake and
// presents {pc, instr} to the IF/ID register through a slot + skid buffer.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        branch_i,
   input  logic [31:0] branch_target_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ready_i,
   input  logic [31:0] imem_data_i,
   output logic [31:0] pc_o,
   output logic [31:0] instr_o,
   output logic        valid_o,
   output logic        flush_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FULL  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] drain_addr_q, drain_addr_d;
   logic        slot_valid_q, slot_valid_d;
   logic [31:0] slot_pc_q, slot_pc_d;
   logic [31:0] slot_instr_q, slot_instr_d;
   logic        skid_valid_q, skid_valid_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic        flush_q, flush_d;

   logic        consume;
   logic        accept;

   assign imem_req_o = (state_q == FETCH) || (state_q == DRAIN);
   assign consume    = slot_valid_q & ~stall_i;
   assign accept     = imem_req_o & imem_ready_i;

   always_comb begin
      imem_addr_o = '0;
      case (state_q)
         FETCH:   imem_addr_o = pc_q;
         DRAIN:   imem_addr_o = drain_addr_q;
         default: imem_addr_o = '0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drain_addr_d = drain_addr_q;
      slot_valid_d = slot_valid_q;
      slot_pc_d    = slot_pc_q;
      slot_instr_d = slot_instr_q;
      skid_valid_d = skid_valid_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      flush_d      = branch_i;

      if (branch_i) begin
         // Redirect wins over everything; an unaccepted request must still be drained.
         pc_d         = branch_target_i;
         slot_valid_d = 1'b0;
         skid_valid_d = 1'b0;
         case (state_q)
            FETCH: begin
               if (accept) begin
                  state_d = FETCH;
               end else begin
                  state_d      = DRAIN;
                  drain_addr_d = pc_q;
               end
            end
            DRAIN:   state_d = imem_ready_i ? FETCH : DRAIN;
            default: state_d = FETCH;
         endcase
      end else begin
         case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
               if (accept) begin
                  pc_d = pc_q + PC_STEP;
                  if (!slot_valid_q || consume) begin
                     slot_valid_d = 1'b1;
                     slot_pc_d    = pc_q;
                     slot_instr_d = imem_data_i;
                  end else begin
                     skid_valid_d = 1'b1;
                     skid_pc_d    = pc_q;
                     skid_instr_d = imem_data_i;
                     state_d      = FULL;
                  end
               end else if (consume) begin
                  slot_valid_d = 1'b0;
               end
            end
            FULL: begin
               if (consume) begin
                  slot_valid_d = skid_valid_q;
                  slot_pc_d    = skid_pc_q;
                  slot_instr_d = skid_instr_q;
                  skid_valid_d = 1'b0;
                  state_d      = FETCH;
               end
            end
            DRAIN: begin
               if (imem_ready_i) begin
                  state_d = FETCH;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         drain_addr_q <= '0;
         slot_valid_q <= 1'b0;
         slot_pc_q    <= '0;
         slot_instr_q <= '0;
         skid_valid_q <= 1'b0;
         skid_pc_q    <= '0;
         skid_instr_q <= '0;
         flush_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drain_addr_q <= drain_addr_d;
         slot_valid_q <= slot_valid_d;
         slot_pc_q    <= slot_pc_d;
         slot_instr_q <= slot_instr_d;
         skid_valid_q <= skid_valid_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
         flush_q      <= flush_d;
      end
   end

   assign pc_o    = slot_pc_q;
   assign instr_o = slot_instr_q;
   assign valid_o = slot_valid_q;
   assign flush_o = flush_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit against a FIFO-level reference model of the
// fetch buffer (capacity 2), drain bookkeeping and PC sequencing.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        stall_i;
   logic        branch_i;
   logic [31:0] branch_target_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ready_i;
   logic [31:0] imem_data_i;
   logic [31:0] pc_o;
   logic [31:0] instr_o;
   logic        valid_o;
   logic        flush_o;

   if_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .stall_i         (stall_i),
      .branch_i        (branch_i),
      .branch_target_i (branch_target_i),
      .imem_req_o      (imem_req_o),
      .imem_addr_o     (imem_addr_o),
      .imem_ready_i    (imem_ready_i),
      .imem_data_i     (imem_data_i),
      .pc_o            (pc_o),
      .instr_o         (instr_o),
      .valid_o         (valid_o),
      .flush_o         (flush_o)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
   endtask

   // Reference model: entries waiting for IF/ID, oldest first.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        fifo[$];
   logic [31:0] m_pc;
   logic        m_idle;
   logic        m_drain;
   logic [31:0] m_drain_addr;
   logic        m_flush;
   logic [31:0] m_last_pc;
   logic [31:0] m_last_instr;

   function automatic logic m_req();
      return !m_idle && (m_drain || fifo.size() < 2);
   endfunction

   function automatic logic [31:0] m_addr();
      if (m_drain) return m_drain_addr;
      if (m_req()) return m_pc;
      return 32'h0;
   endfunction

   task automatic model_reset();
      fifo.delete();
      m_pc         = 32'h0;
      m_idle       = 1'b1;
      m_drain      = 1'b0;
      m_drain_addr = 32'h0;
      m_flush      = 1'b0;
      m_last_pc    = 32'h0;
      m_last_instr = 32'h0;
   endtask

   task automatic model_step(input logic rst, input logic stall, input logic br,
                             input logic [31:0] tgt, input logic ready, input logic [31:0] data);
      logic req, accept, consume;
      if (!rst) begin
         model_reset();
         return;
      end
      req     = m_req();
      accept  = req && ready;
      consume = (fifo.size() > 0) && !stall;
      m_flush = br;
      if (br) begin
         fifo.delete();
         if (m_drain) begin
            if (ready) m_drain = 1'b0;
         end else if (req && !accept) begin
            m_drain      = 1'b1;
            m_drain_addr = m_pc;
         end
         m_pc = tgt;
      end else if (m_drain) begin
         if (ready) m_drain = 1'b0;
      end else begin
         if (consume) void'(fifo.pop_front());
         if (accept) begin
            fifo.push_back('{pc: m_pc, instr: data});
            m_pc = m_pc + 32'd4;
         end
      end
      m_idle = 1'b0;
      if (fifo.size() > 0) begin
         m_last_pc    = fifo[0].pc;
         m_last_instr = fifo[0].instr;
      end
   endtask

   task automatic compare_outputs();
      logic exp_req;
      exp_req = m_req();
      check("req", {31'b0, imem_req_o}, {31'b0, exp_req});
      check("valid", {31'b0, valid_o}, {31'b0, (fifo.size() > 0)});
      check("flush", {31'b0, flush_o}, {31'b0, m_flush});
      check("pc", pc_o, m_last_pc);
      check("instr", instr_o, m_last_instr);
      if (exp_req || m_idle) check("addr", imem_addr_o, m_addr());
   endtask

   // One clock: drive at negedge, compare settled outputs, advance model at posedge.
   task automatic cycle(input logic rst, input logic stall, input logic br,
                        input logic [31:0] tgt, input logic ready);
      logic [31:0] data;
      @(negedge clk);
      data            = $urandom;
      rst_i           = rst;
      stall_i         = stall;
      branch_i        = br;
      branch_target_i = tgt;
      imem_ready_i    = ready;
      imem_data_i     = data;
      compare_outputs();
      @(posedge clk);
      model_step(rst, stall, br, tgt, ready, data);
   endtask

   task automatic rand_cycle(input int unsigned p_ready, input int unsigned p_stall,
                             input int unsigned p_br, input int unsigned p_rst);
      logic [31:0] tgt;
      tgt = {$urandom_range(0, 32'h3FFF), 2'b00};
      cycle(($urandom_range(0, 99) >= p_rst), ($urandom_range(0, 99) < p_stall),
            ($urandom_range(0, 99) < p_br), tgt, ($urandom_range(0, 99) < p_ready));
   endtask

   initial begin
      rst_i           = 1'b0;
      stall_i         = 1'b0;
      branch_i        = 1'b0;
      branch_target_i = 32'h0;
      imem_ready_i    = 1'b0;
      imem_data_i     = 32'h0;
      repeat (2) @(posedge clk);
      model_reset();

      // Zero-wait memory, no stall: one instruction per cycle.
      for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

      // Slow memory with stalls filling the skid.
      for (int i = 0; i < 300; i++) rand_cycle(35, 40, 0, 0);

      // Branch while a request is pending, then reset during the drain.
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 32'h100, 1'b0);
      for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

      // Fill both entries under stall, then branch+stall together.
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      cycle(1'b1, 1'b1, 1'b1, 32'h200, 1'b1);
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

      // Branch in DRAIN with ready in the same cycle.
      cycle(1'b1, 1'b0, 1'b1, 32'h300, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 32'h400, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

      // Fully random mix, including occasional resets.
      for (int i = 0; i < 3000; i++) rand_cycle(60, 30, 8, 2);
      for (int i = 0; i < 1000; i++) rand_cycle(95, 10, 3, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
